// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
// Holds the PC mux select encoding, the FSM state type and the default reset vector.
package pc_fetch_ctrl_pkg;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_JALR = 2'b01;
    localparam logic [1:0] PC_SRC_IMM  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory handshake plus the execute-stage redirect/control signals.
// master = fetch controller, slave = memory/execute side.
interface pc_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic [31:0] fetch_pc;
    logic        branch_taken;
    logic [31:0] imm_address;
    logic        jalr_en;
    logic [31:0] pc_next;
    logic        stall;
    logic        halt;
    logic [1:0]  pc_src;

    modport master (
        output imem_req, imem_addr, instr_valid, fetch_pc, pc_src,
        input  imem_ack, branch_taken, imm_address, jalr_en, pc_next, stall, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, fetch_pc, pc_src,
        output imem_ack, branch_taken, imm_address, jalr_en, pc_next, stall, halt
    );

endinterface

// File: rtl/pc_fetch_ctrl_mux.sv
// Next-PC mux: selects PC+4, the JALR target or the branch/JAL immediate target.
module pc_fetch_ctrl_mux
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm_address,
    input  logic [31:0] pc_next,
    input  logic [1:0]  pc_src,
    output logic [31:0] pc_mux_out
);

    always_comb begin
        case (pc_src)
            PC_SRC_JALR: pc_mux_out = pc_next;
            PC_SRC_IMM:  pc_mux_out = imm_address;
            default:     pc_mux_out = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32I program counter sequencer: owns the PC, runs the imem req/ack handshake,
// picks the next-PC source and handles stall, halt and misaligned-target faults.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | one cycle after reset release, no request
// ST_FETCH  | imem_req high, waiting for / taking the ack
// ST_HOLD   | stalled after retire, request dropped until stall clears
// ST_HALTED | ECALL/EBREAK retired, frozen until reset
// ST_FAULT  | misaligned redirect target captured, frozen until reset
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_fetch_ctrl_if.master       bus,
    output logic                  fault,
    output logic [31:0]           fault_pc,
    output logic                  halted,
    output logic [63:0]           instret
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [1:0]   sel;
    logic         ack_fire;
    logic         target_bad;

    pc_fetch_ctrl_mux u_pc_mux (
        .pc_plus4    (pc + 32'd4),
        .imm_address (bus.imm_address),
        .pc_next     (bus.pc_next),
        .pc_src      (sel),
        .pc_mux_out  (target)
    );

    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.fetch_pc    = pc;
    assign bus.instr_valid = ack_fire;
    assign bus.pc_src      = sel;

    // Sequential PC+4 is always aligned, so only redirects can fault.
    assign target_bad = (sel != PC_SRC_SEQ) && is_misaligned(target);

    always_comb begin
        ack_fire  = (state == ST_FETCH) && bus.imem_ack;
        sel       = PC_SRC_SEQ;
        state_nxt = state;

        if (ack_fire) begin
            if (bus.jalr_en)
                sel = PC_SRC_JALR;
            else if (bus.branch_taken)
                sel = PC_SRC_IMM;
        end

        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (ack_fire) begin
                    if (target_bad)
                        state_nxt = ST_FAULT;
                    else if (bus.halt)
                        state_nxt = ST_HALTED;
                    else if (bus.stall)
                        state_nxt = ST_HOLD;
                end
            end
            ST_HOLD:  if (!bus.stall) state_nxt = ST_FETCH;
            default:  state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_VECTOR;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
            halted   <= 1'b0;
            instret  <= 64'h0;
        end else begin
            state <= state_nxt;
            if (ack_fire) begin
                if (target_bad) begin
                    fault    <= 1'b1;
                    fault_pc <= target;
                end else begin
                    pc      <= target;
                    instret <= instret + 64'd1;
                    if (bus.halt)
                        halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Sequencer for the RV32I program counter. It owns the PC register and runs the request/acknowledge handshake with instruction memory. It chooses the next-PC source (sequential, branch/JAL immediate target, JALR target), drives the select of the existing PC mux, and handles stall, halt and misaligned-target fault. It sits between instruction memory and the decode/execute stage of the single-cycle core.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals the PC register.
- imem_ack  input  1  memory returns the instruction this cycle; may be high in the same cycle as imem_req (zero-wait).
- instr_valid  output  1  one-cycle pulse; the instruction at fetch_pc executes this cycle.
- fetch_pc  output  32  PC of the executing instruction; equals imem_addr.
- branch_taken  input  1  conditional branch or JAL taken; qualified by instr_valid.
- imm_address  input  32  branch/JAL target.
- jalr_en  input  1  JALR executing; qualified by instr_valid.
- pc_next  input  32  JALR target, with bit 0 already cleared by the ALU path.
- stall  input  1  hold fetch after the current instruction retires.
- halt  input  1  ECALL/EBREAK executing; stop after this instruction.
- pc_src  output  2  mux select: 00 = PC+4, 01 = pc_next, 10 = imm_address. Forced to 00 when instr_valid = 0.
- fault  output  1  sticky flag: misaligned target detected.
- fault_pc  output  32  offending target address.
- halted  output  1  sticky flag: the core is halted.
- instret  output  64  count of retired instructions.

## Operation
- States: IDLE, FETCH, HOLD, HALTED, FAULT.
- Reset values: state = IDLE, pc = RESET_VECTOR, imem_req = 0, instr_valid = 0, pc_src = 00, fault = 0, fault_pc = 0, halted = 0, instret = 0.
- IDLE: after reset deasserts, moves unconditionally to FETCH on the next edge.
- FETCH: imem_req = 1. While imem_ack = 0, the PC holds and imem_addr stays stable.
  - On imem_ack = 1, instr_valid = 1 combinationally in that cycle.
  - Source priority: jalr_en (01) > branch_taken (10) > sequential (00).
  - The PC loads the mux output at the clock edge, and instret increments.
- Fault check at ack: if the selected target has bits [1:0] ≠ 00 (branch/JALR targets only):
  - instr_valid is still 1, but the PC is not updated and instret does not increment;
  - fault_pc is loaded with the target, fault = 1, next state = FAULT.
- Stall at ack (no fault): the PC updates normally, next state = HOLD.
  - A stall sampled while waiting for ack has no effect; the handshake is never abandoned.
- HOLD: imem_req = 0. Returns to FETCH on the first cycle in which stall = 0.
- Halt at ack (no fault): the PC updates, instret increments, halted = 1, next state = HALTED.
- Simultaneous events at ack: fault > halt > stall.
- HALTED and FAULT are terminal: imem_req = 0, outputs frozen, and only rst_n exits.
- Arithmetic:
  - PC+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
  - instret is a 64-bit wrapping counter.

## Timing
- Fetch latency is 1 cycle per instruction with a zero-wait memory (ack in the same cycle as req); otherwise 1 + N wait cycles.
- The redirect target appears on imem_addr in the cycle after the ack; there are no bubbles and no wrong-path fetch.
- First request: imem_req rises in the second cycle after rst_n deasserts (one IDLE cycle).
- Outputs: pc_src and instr_valid are combinational from state, imem_ack, jalr_en and branch_taken. All other outputs are registered.
- Reset mid-transaction: imem_req drops asynchronously. Instruction memory must tolerate an abandoned request and ignore a late ack arriving in IDLE.

## Structure
- Shared package holds:
  - the pc_src encoding constants PC_SRC_SEQ = 2'b00, PC_SRC_JALR = 2'b01, PC_SRC_IMM = 2'b10;
  - the state enum;
  - the default reset vector.
- One sub-module: an instance of the existing PcMux, fed with pc + 4, imm_address and pc_next, selected by pc_src. The controller adds the FSM, PC register, fault capture and instret.

## Test plan
- Reset with RESET_VECTOR = 32'h100 and zero-wait memory → imem_addr reads 0x100, 0x104, 0x108 on consecutive cycles; instret = 3 after three acks.
- Ack delayed 3 cycles at 0x104 → imem_req held high and imem_addr stable at 0x104 for 4 cycles; exactly one instr_valid pulse.
- branch_taken and jalr_en both high at ack (imm_address = 0x200, pc_next = 0x300) → pc_src = 01 and the next imem_addr = 0x300.
- branch_taken at ack with imm_address = 0x202 → fault = 1, fault_pc = 0x202, imem_req = 0 from the next cycle; PC and instret unchanged.
- stall high for 2 cycles at ack at 0x10 → next PC 0x14, imem_req low for 2 cycles, then a fetch of 0x14; halt at ack at 0x14 → halted = 1, no further requests.
- PC at 0xFFFF_FFFC, sequential ack → next imem_addr = 0x0; assert rst_n low mid-wait → imem_req falls immediately and PC returns to RESET_VECTOR.
